// File: rtl/ula_multiciclo.sv
// ula_multiciclo: RISC-V ALU, single-cycle logic/add/shift/compare plus iterative MUL/MULHU and (with ULA_DIV_EN) DIV/DIVU/REM/REMU.
// Latency: 1 cycle from accept for single-cycle ops and divide special cases, WIDTH+1 cycles for multiply/divide.
// Backpressure: in_ready only while idle; result and flags are held stable in PRONTO until out_ready.
module ula_multiciclo #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [3:0]       ula_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ula_result,
   output logic             zero_flag,
   output logic             div_zero,
   output logic             op_invalid
);

   typedef enum logic [1:0] {OCIOSO, CALC, PRONTO} state_t;

   state_t             state;
   logic [3:0]         op_q;
   logic [WIDTH-1:0]   b_q;        // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] prod;       // product register / {remainder, quotient}
   logic [2*WIDTH-1:0] step_prod;
   logic [SHW:0]       cnt;
   logic [WIDTH-1:0]   imm_res;
   logic [WIDTH-1:0]   fin_res;
   logic               imm_multi;
   logic               imm_dz;
   logic               imm_inv;
   logic [WIDTH:0]     mul_sum;
   logic [SHW-1:0]     shamt;

   assign shamt    = in2[SHW-1:0];
   assign in_ready = (state == OCIOSO) && !rst;

`ifdef ULA_DIV_EN
   logic             sgn_op;
   logic             a_neg;
   logic             b_neg;
   logic             ovf;
   logic             neg_q;
   logic             neg_r;
   logic [WIDTH-1:0] mag1;
   logic [WIDTH-1:0] mag2;
   logic [WIDTH:0]   r_sh;
   logic [WIDTH:0]   diff;

   // DIV/REM are signed (opcode bit 0 clear); the divider works on magnitudes.
   assign sgn_op = ~ula_control[0];
   assign a_neg  = sgn_op & in1[WIDTH-1];
   assign b_neg  = sgn_op & in2[WIDTH-1];
   assign mag1   = a_neg ? -in1 : in1;
   assign mag2   = b_neg ? -in2 : in2;
   assign ovf    = sgn_op && (in1 == {1'b1, {(WIDTH-1){1'b0}}}) && (in2 == '1);
`endif

   // Result of everything that completes at capture, and whether the op needs iteration.
   always_comb begin
      imm_res   = '0;
      imm_multi = 1'b0;
      imm_dz    = 1'b0;
      imm_inv   = 1'b0;
      case (ula_control)
         4'b0000: imm_res = in1 & in2;
         4'b0001: imm_res = in1 | in2;
         4'b0010: imm_res = in1 + in2;
         4'b0011: imm_res = in1 << shamt;
         4'b0100: imm_res = in1 - in2;
         4'b0101: imm_res = in1 >> shamt;
         4'b0111: imm_res = in1 ^ in2;
         4'b1000: imm_res = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
         4'b1001: imm_res = {{(WIDTH-1){1'b0}}, in1 < in2};
         4'b1010: imm_res = $signed(in1) >>> shamt;
         4'b0110, 4'b1011: imm_multi = 1'b1;
         default: begin
`ifdef ULA_DIV_EN
            if (in2 == '0) begin
               imm_dz  = 1'b1;
               imm_res = ula_control[1] ? in1 : '1;
            end else if (ovf) begin
               imm_res = ula_control[1] ? '0 : in1;
            end else begin
               imm_multi = 1'b1;
            end
`else
            imm_inv = 1'b1;
`endif
         end
      endcase
   end

   // One shift-add multiply step, or one restoring-divide step for opcodes 11xx.
   always_comb begin
      mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, b_q} : '0);
      step_prod = {mul_sum, prod[WIDTH-1:1]};
`ifdef ULA_DIV_EN
      r_sh = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
      diff = r_sh - {1'b0, b_q};
      if (op_q[3:2] == 2'b11) begin
         if (!diff[WIDTH]) step_prod = {diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
         else              step_prod = {r_sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
      end
`endif
   end

   // Pick the result half after the last step and apply the divide sign fix-up.
   always_comb begin
      fin_res = (op_q == 4'b1011) ? step_prod[2*WIDTH-1:WIDTH] : step_prod[WIDTH-1:0];
`ifdef ULA_DIV_EN
      if (op_q[3:2] == 2'b11) begin
         if (op_q[1]) fin_res = neg_r ? -step_prod[2*WIDTH-1:WIDTH] : step_prod[2*WIDTH-1:WIDTH];
         else         fin_res = neg_q ? -step_prod[WIDTH-1:0] : step_prod[WIDTH-1:0];
      end
`endif
   end

   // Control FSM with registered result, flags and out_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= OCIOSO;
         out_valid  <= 1'b0;
         ula_result <= '0;
         zero_flag  <= 1'b0;
         div_zero   <= 1'b0;
         op_invalid <= 1'b0;
      end else begin
         case (state)
            OCIOSO: if (in_valid) begin
               op_q       <= ula_control;
               div_zero   <= imm_dz;
               op_invalid <= imm_inv;
               if (imm_multi) begin
                  cnt   <= (SHW+1)'(WIDTH);
                  state <= CALC;
`ifdef ULA_DIV_EN
                  if (ula_control[3:2] == 2'b11) begin
                     b_q   <= mag2;
                     prod  <= {{WIDTH{1'b0}}, mag1};
                     neg_q <= a_neg ^ b_neg;
                     neg_r <= a_neg;
                  end else begin
                     b_q  <= in1;
                     prod <= {{WIDTH{1'b0}}, in2};
                  end
`else
                  b_q  <= in1;
                  prod <= {{WIDTH{1'b0}}, in2};
`endif
               end else begin
                  ula_result <= imm_res;
                  zero_flag  <= (imm_res == '0);
                  out_valid  <= 1'b1;
                  state      <= PRONTO;
               end
            end
            CALC: begin
               prod <= step_prod;
               cnt  <= cnt - {{SHW{1'b0}}, 1'b1};
               if (cnt == {{SHW{1'b0}}, 1'b1}) begin
                  ula_result <= fin_res;
                  zero_flag  <= (fin_res == '0);
                  out_valid  <= 1'b1;
                  state      <= PRONTO;
               end
            end
            PRONTO: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= OCIOSO;
            end
            default: state <= OCIOSO;
         endcase
      end
   end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Testbench for ula_multiciclo (WIDTH = 32): directed scenarios plus randomized ops against a plain-arithmetic model.
// Handles both builds: divider tests follow ULA_DIV_EN.
`timescale 1ns/1ps
module tb_ula_multiciclo;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in1 = '0;
   logic [W-1:0] in2 = '0;
   logic [3:0]   ula_control = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] ula_result;
   logic         zero_flag;
   logic         div_zero;
   logic         op_invalid;

   int checks = 0;
   int errors = 0;

   ula_multiciclo #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .ula_control(ula_control),
      .out_valid(out_valid), .out_ready(out_ready), .ula_result(ula_result),
      .zero_flag(zero_flag), .div_zero(div_zero), .op_invalid(op_invalid)
   );

   always #5 clk = ~clk;

   // Reference model: RISC-V semantics with 64-bit arithmetic; lat = cycles from accept to out_valid.
   function automatic void model(input bit [3:0] op, input bit [31:0] a, input bit [31:0] b,
                                 output bit [31:0] r, output bit dz, output bit inv, output int lat);
      longint          sa;
      longint          sb;
      longint unsigned ua;
      longint unsigned ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = a;
      ub = b;
      r = 0; dz = 0; inv = 0; lat = 1;
      case (op)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  r = a + b;
         4'd3:  r = a << b[4:0];
         4'd4:  r = a - b;
         4'd5:  r = a >> b[4:0];
         4'd6:  begin r = 32'(ua * ub); lat = 33; end
         4'd7:  r = a ^ b;
         4'd8:  r = (sa < sb) ? 1 : 0;
         4'd9:  r = (a < b) ? 1 : 0;
         4'd10: r = 32'(sa >>> b[4:0]);
         4'd11: begin r = 32'((ua * ub) >> 32); lat = 33; end
         default: begin
`ifdef ULA_DIV_EN
            if (b == 0) begin
               dz = 1;
               r  = op[1] ? a : 32'hFFFF_FFFF;
            end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               r = op[1] ? 32'h0 : a;
            end else begin
               lat = 33;
               if (op[0]) r = op[1] ? a % b : a / b;
               else       r = op[1] ? 32'(sa % sb) : 32'(sa / sb);
            end
`else
            inv = 1;
`endif
         end
      endcase
   endfunction

   // Issue one op; returns sampled outputs, latency (-1 on timeout) and whether in_ready was seen while busy.
   task automatic do_op(input bit [3:0] op, input bit [31:0] a, input bit [31:0] b,
                        output bit [31:0] res, output bit zf, output bit dz, output bit inv,
                        output int lat, output bit busy_rdy);
      int g;
      in1 = a; in2 = b; ula_control = op; in_valid = 1'b1;
      g = 0;
      while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in1 = $urandom; in2 = $urandom; ula_control = 4'($urandom);
      lat = 1; busy_rdy = 1'b0;
      while (!out_valid && lat < 200) begin
         if (in_ready) busy_rdy = 1'b1;
         @(posedge clk); #1; lat++;
      end
      if (in_ready) busy_rdy = 1'b1;
      if (!out_valid) lat = -1;
      res = ula_result; zf = zero_flag; dz = div_zero; inv = op_invalid;
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, zero_flag, div_zero, op_invalid} !== 5'b0) begin
         errors++; $display("FAIL reset_flags got %b want 00000", {in_ready, out_valid, zero_flag, div_zero, op_invalid});
      end
      checks++;
      if (ula_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", ula_result); end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
   endtask

   task automatic test_add_hold();
      bit [31:0] r; bit zf, dz, inv, bz; int lat;
      do_op(4'd2, 32'hFFFF_FFFF, 32'h1, r, zf, dz, inv, lat, bz);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
      checks++;
      if ({r, zf, dz, inv} !== {32'h0, 3'b100}) begin
         errors++; $display("FAIL add_result got %h z%b d%b i%b want 0 z1 d0 i0", r, zf, dz, inv);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({out_valid, in_ready, ula_result, zero_flag} !== {2'b10, 32'h0, 1'b1}) begin
            errors++; $display("FAIL add_hold%0d got v%b r%b %h z%b want v1 r0 0 z1", i, out_valid, in_ready, ula_result, zero_flag);
         end
      end
      take();
   endtask

   task automatic test_shift_cmp();
      bit [3:0]  ops  [3] = '{4'd10, 4'd8, 4'd9};
      bit [31:0] as   [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      bit [31:0] bs   [3] = '{32'h0000_0024, 32'h1, 32'h1};
      bit [31:0] exps [3] = '{32'hF800_0000, 32'h1, 32'h0};
      bit [31:0] r; bit zf, dz, inv, bz; int lat;
      for (int i = 0; i < 3; i++) begin
         do_op(ops[i], as[i], bs[i], r, zf, dz, inv, lat, bz);
         checks++;
         if (r !== exps[i] || lat !== 1) begin
            errors++; $display("FAIL shift_cmp%0d got %h lat %0d want %h lat 1", i, r, lat, exps[i]);
         end
         take();
      end
   endtask

   task automatic test_mul();
      bit [31:0] r; bit zf, dz, inv, bz; int lat;
      do_op(4'd6, 32'hFFFF_FFFF, 32'h2, r, zf, dz, inv, lat, bz);
      checks++;
      if (r !== 32'hFFFF_FFFE || lat !== 33) begin errors++; $display("FAIL mul got %h lat %0d want fffffffe lat 33", r, lat); end
      checks++;
      if (bz !== 1'b0) begin errors++; $display("FAIL mul_busy_ready got %b want 0", bz); end
      take();
      do_op(4'd11, 32'hFFFF_FFFF, 32'h2, r, zf, dz, inv, lat, bz);
      checks++;
      if (r !== 32'h1 || lat !== 33 || bz !== 1'b0) begin
         errors++; $display("FAIL mulhu got %h lat %0d busy %b want 00000001 lat 33 busy 0", r, lat, bz);
      end
      take();
   endtask

   task automatic test_div();
      bit [31:0] r; bit zf, dz, inv, bz; int lat;
`ifdef ULA_DIV_EN
      do_op(4'd12, 32'hFFFF_FFF9, 32'h2, r, zf, dz, inv, lat, bz);
      checks++;
      if (r !== 32'hFFFF_FFFD || lat !== 33) begin errors++; $display("FAIL div got %h lat %0d want fffffffd lat 33", r, lat); end
      take();
      do_op(4'd14, 32'hFFFF_FFF9, 32'h2, r, zf, dz, inv, lat, bz);
      checks++;
      if (r !== 32'hFFFF_FFFF || lat !== 33) begin errors++; $display("FAIL rem got %h lat %0d want ffffffff lat 33", r, lat); end
      take();
      do_op(4'd13, 32'h5, 32'h0, r, zf, dz, inv, lat, bz);
      checks++;
      if (r !== 32'hFFFF_FFFF || dz !== 1'b1 || inv !== 1'b0 || lat !== 1) begin
         errors++; $display("FAIL divu_zero got %h dz %b inv %b lat %0d want ffffffff dz 1 inv 0 lat 1", r, dz, inv, lat);
      end
      take();
      do_op(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, r, zf, dz, inv, lat, bz);
      checks++;
      if (r !== 32'h8000_0000 || dz !== 1'b0 || lat !== 1) begin
         errors++; $display("FAIL div_ovf got %h dz %b lat %0d want 80000000 dz 0 lat 1", r, dz, lat);
      end
      take();
`else
      do_op(4'd13, 32'd10, 32'd3, r, zf, dz, inv, lat, bz);
      checks++;
      if ({r, zf, dz, inv} !== {32'h0, 3'b101} || lat !== 1) begin
         errors++; $display("FAIL divu_invalid got %h z%b d%b i%b lat %0d want 0 z1 d0 i1 lat 1", r, zf, dz, inv, lat);
      end
      take();
`endif
   endtask

   task automatic test_abort();
      bit [31:0] r; bit zf, dz, inv, bz; int lat; bit seen;
      in1 = 32'h1234_5678; in2 = 32'h9; ula_control = 4'd6; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, ula_result} !== {2'b00, 32'h0}) begin
         errors++; $display("FAIL abort_in_reset got v%b r%b %h want v0 r0 0", out_valid, in_ready, ula_result);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL abort_release got r%b v%b want r1 v0", in_ready, out_valid);
      end
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_result got out_valid %b want 0", seen); end
      do_op(4'd2, 32'd3, 32'd4, r, zf, dz, inv, lat, bz);
      checks++;
      if (r !== 32'd7 || lat !== 1) begin errors++; $display("FAIL abort_next_add got %h lat %0d want 7 lat 1", r, lat); end
      take();
   endtask

   task automatic test_back_to_back();
      in1 = 32'd1; in2 = 32'd2; ula_control = 4'd2; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, ula_result} !== {2'b10, 32'd3}) begin
         errors++; $display("FAIL b2b_first got v%b r%b %h want v1 r0 3", out_valid, in_ready, ula_result);
      end
      in1 = 32'd5; in2 = 32'd6;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++; $display("FAIL b2b_gap got v%b r%b want v0 r1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, ula_result} !== {1'b1, 32'd11}) begin
         errors++; $display("FAIL b2b_second got v%b %h want v1 b", out_valid, ula_result);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      bit [31:0] a, b, r, er; bit zf, dz, inv, bz, edz, einv; int lat, elat; bit [3:0] op;
      for (int i = 0; i < 80; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         case ($urandom_range(0, 4))
            0: b = 32'h0;
            1: b = 32'($urandom_range(1, 40));
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: b = $urandom;
         endcase
         model(op, a, b, er, edz, einv, elat);
         do_op(op, a, b, r, zf, dz, inv, lat, bz);
         checks++;
         if ({r, zf, dz, inv} !== {er, er == 32'h0, edz, einv} || lat !== elat || bz !== 1'b0) begin
            errors++;
            $display("FAIL rand%0d op %0d a %h b %h got %h z%b d%b i%b lat %0d busy %b want %h z%b d%b i%b lat %0d busy 0",
                     i, op, a, b, r, zf, dz, inv, lat, bz, er, er == 32'h0, edz, einv, elat);
         end
         take();
      end
   endtask

   initial begin
      test_reset();
      test_add_hold();
      test_shift_cmp();
      test_mul();
      test_div();
      test_abort();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ula_multiciclo.md
# ula_multiciclo

Parametrised multi-cycle ALU for the RISC-V datapath, with a valid/ready handshake on both sides. Logic, add/sub, shifts and compares finish in one cycle. Multiply and divide/remainder run iteratively over WIDTH cycles. It sits between the operand-read stage and write-back; the control unit stalls on `in_ready`/`out_valid`.

## Interface
- `WIDTH`, 32: operand/result width; power of two, ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width, derived; do not override.

Ports:
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `in_valid` input 1: operands and opcode valid.
- `in_ready` output 1: block can accept an operation.
- `in1` input WIDTH: operand A.
- `in2` input WIDTH: operand B.
- `ula_control` input 4: opcode.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer takes the result.
- `ula_result` output WIDTH: result, registered.
- `zero_flag` output 1: `ula_result == 0`, registered with the result.
- `div_zero` output 1: the divide/remainder divisor was 0.
- `op_invalid` output 1: the opcode is not supported in this build.

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SUB, 0101 SRL, 0110 MUL (low WIDTH), 0111 XOR.
  - 1000 SLT (signed), 1001 SLTU, 1010 SRA, 1011 MULHU (high WIDTH, unsigned).
  - 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
- Shift opcodes use only `in2[SHW-1:0]`. SRA fills with `in1[WIDTH-1]`.
- ADD/SUB/MUL wrap modulo 2^WIDTH. SLT/SLTU return 1 or 0, zero-extended.
- MUL/MULHU use a shift-add multiplier with a 2·WIDTH product register.
- Division uses a restoring divider on magnitudes; signs are fixed up at the end:
  - quotient is negative iff the operand signs differ;
  - remainder takes the sign of the dividend.
- Divide by zero (divisor 0, DIV/DIVU/REM/REMU):
  - quotient = all ones; remainder = `in1`;
  - `div_zero` = 1; no iteration.
- Signed overflow (DIV/REM with `in1` = 2^(WIDTH-1) and `in2` = all ones):
  - quotient = `in1`; remainder = 0; no iteration.
- FSM has three states: OCIOSO, CALC, PRONTO.
  - OCIOSO: `in_ready` = 1. When `in_valid`, operands and opcode are captured.
    - Single-cycle op or special case: go to PRONTO.
    - MUL/MULHU/normal divide: go to CALC with the counter loaded with WIDTH.
  - CALC: one iteration per cycle, counter decrements. At 0, write the result and go to PRONTO.
  - PRONTO: `out_valid` = 1; result and flags are held stable. When `out_ready`, go to OCIOSO.
- `in_ready` = 0 in CALC and PRONTO. There is no same-cycle back-to-back accept.
- `in1`/`in2`/`ula_control` are ignored after capture; changing them mid-operation has no effect.
- `div_zero` and `op_invalid` are valid only while `out_valid` = 1. They clear when a new operation is captured.

## Timing
- Reset values: state OCIOSO, `out_valid` 0, `ula_result` 0, `zero_flag` 0, `div_zero` 0, `op_invalid` 0.
- `in_ready` = 0 while `rst` = 1 and 1 in the first cycle after reset is released.
- Single-cycle ops, divide by zero, signed overflow, invalid opcode: accepted at edge N, `out_valid` = 1 after edge N+1.
- MUL/MULHU/DIV/DIVU/REM/REMU: accepted at edge N, `out_valid` = 1 after edge N+WIDTH+1. That is 33 cycles for WIDTH = 32.
- `rst` in CALC or PRONTO aborts the operation; outputs return to reset values on the next edge.
- If `out_ready` is held high, the next accept is possible 1 cycle after the result transfer.

## Configuration
- `ULA_DIV_EN` defined: the divider and opcodes 1100–1111 are built as specified.
- `ULA_DIV_EN` not defined: no divider logic.
  - Opcodes 1100–1111 complete in one cycle with `ula_result` = 0, `zero_flag` = 1, `op_invalid` = 1, `div_zero` = 0.
- All other opcodes never set `op_invalid`.

## Test plan
- Reset, then ADD 0xFFFFFFFF + 1: `out_valid` 1 cycle after accept, result 0x00000000, `zero_flag` 1. Hold `out_ready` = 0 for 5 cycles: result stays stable.
- SRA 0x80000000 by `in2` = 0x00000024 (amount 4): result 0xF8000000. SLT −1 vs 1 → 1; SLTU −1 vs 1 → 0.
- MUL 0xFFFFFFFF × 2: result 0xFFFFFFFE after 33 cycles. MULHU same operands: result 0x00000001. `in_ready` = 0 throughout CALC.
- With `ULA_DIV_EN`:
  - DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF (both 33 cycles).
  - DIVU 5 / 0 → 0xFFFFFFFF, `div_zero` 1, 1 cycle.
  - DIV 0x80000000 / −1 → 0x80000000, 1 cycle.
- Without `ULA_DIV_EN`: DIVU 10 / 3 → result 0, `op_invalid` 1, 1 cycle.
- Assert `rst` at cycle 10 of a MUL: `out_valid` stays 0, `in_ready` = 1 after release. The next ADD 3 + 4 returns 7.
